// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the in-order pipeline control unit.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_IVT  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic EPC_DEC = 1'b0;
  localparam logic EPC_BR  = 1'b1;

endpackage

// File: rtl/pipeline_perf_cnt.sv
// Saturating event counter; holds at all-ones once full.
module pipeline_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register enable/flush, PC select and interrupt-entry sequencing.
// Optional perf counters (stall/flush/int) are built when PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES     = 5,
  parameter int EX_STAGE   = 2,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rsrc1,
  input  logic [REG_ADDR_W-1:0] id_rsrc2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rdst,
  input  logic                  br_taken,
  input  logic                  int_req,
  output logic [STAGES-2:0]     stage_en,
  output logic [STAGES-2:0]     stage_flush,
  output logic [1:0]            pc_sel,
  output logic                  epc_load,
  output logic                  epc_src,
  output logic                  int_ack
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      int_cnt
`endif
);

  localparam int NREG = STAGES - 1;
  localparam int DCW  = $clog2(STAGES);
  localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(STAGES - EX_STAGE - 1);
  // Registers feeding execute and everything younger.
  localparam logic [NREG-1:0] FRONT_MASK = NREG'((64'd1 << EX_STAGE) - 64'd1);
  localparam logic [NREG-1:0] EX_BUBBLE  = NREG'(64'd1 << (EX_STAGE - 1));

  if (EX_STAGE < 1 || EX_STAGE > STAGES - 2) begin : gBadEx
    $error("EX_STAGE out of range");
  end
  if (CNT_W < 1) begin : gBadCnt
    $error("CNT_W must be positive");
  end

  ctrl_state_e    state, stateNxt;
  logic [DCW-1:0] drainCnt, drainNxt;
  logic           armed, armedNxt;
  logic           loadUse, accept;

  assign loadUse = id_valid & ex_valid & ex_mem_read &
                   ((id_use1 & (id_rsrc1 == ex_rdst)) | (id_use2 & (id_rsrc2 == ex_rdst)));
  assign accept  = (state == RUN) & int_req & armed & ~br_taken & ~loadUse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      drainCnt <= '0;
      armed    <= 1'b1;
    end else begin
      state    <= stateNxt;
      drainCnt <= drainNxt;
      armed    <= armedNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    drainNxt = drainCnt;
    // A low request re-arms; a request held across entry is not taken twice.
    armedNxt = int_req ? armed : 1'b1;
    unique case (state)
      RUN: if (accept) begin
        stateNxt = DRAIN;
        drainNxt = DRAIN_LOAD;
        armedNxt = 1'b0;
      end
      DRAIN: begin
        if (drainCnt == '0) stateNxt = VECTOR;
        else                drainNxt = drainCnt - 1'b1;
      end
      VECTOR:  stateNxt = RUN;
      default: stateNxt = RUN;
    endcase
  end

  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    pc_sel      = PC_SEQ;
    epc_load    = 1'b0;
    epc_src     = EPC_DEC;
    int_ack     = 1'b0;
    if (!rst) begin
      stage_flush = '1;
      pc_sel      = PC_HOLD;
    end else begin
      unique case (state)
        RUN: begin
          if (br_taken) begin
            stage_flush = FRONT_MASK;
            pc_sel      = PC_BR;
          end else if (loadUse) begin
            stage_en[0] = 1'b0;
            stage_flush = EX_BUBBLE;
            pc_sel      = PC_HOLD;
          end else if (accept) begin
            stage_flush = FRONT_MASK;
            pc_sel      = PC_HOLD;
            epc_load    = 1'b1;
          end
        end
        DRAIN: begin
          stage_flush = FRONT_MASK;
          pc_sel      = PC_HOLD;
          // Branch resolving under drain: resume point becomes its target.
          if (br_taken) begin
            epc_load = 1'b1;
            epc_src  = EPC_BR;
          end
        end
        VECTOR: begin
          stage_flush[0] = 1'b1;
          pc_sel         = PC_IVT;
          int_ack        = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic stallInc, flushInc;
  assign stallInc = (state == RUN) & ~br_taken & loadUse;
  assign flushInc = (state == RUN) & br_taken;

  pipeline_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (.clk(clk), .rst(rst), .inc(stallInc), .cnt(stall_cnt));
  pipeline_perf_cnt #(.CNT_W(CNT_W)) uFlushCnt (.clk(clk), .rst(rst), .inc(flushInc), .cnt(flush_cnt));
  pipeline_perf_cnt #(.CNT_W(CNT_W)) uIntCnt   (.clk(clk), .rst(rst), .inc(int_ack),  .cnt(int_cnt));
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes reference-model results, negedge monitor pops and compares.
module tb_pipeline_ctrl;
  localparam int STAGES = 5;
  localparam int EX     = 2;
  localparam int AW     = 3;
  localparam int CW     = 16;
  localparam int NREG   = STAGES - 1;
  localparam int DRAINC = STAGES - EX;

  typedef struct packed {
    logic          rstn;
    logic          idv;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic          exv;
    logic          exm;
    logic [AW-1:0] rd;
    logic          br;
    logic          ir;
  } stim_t;

  typedef struct packed {
    logic [NREG-1:0] en;
    logic [NREG-1:0] flush;
    logic [1:0]      pc;
    logic            epcLoad;
    logic            epcSrc;
    logic            ack;
`ifdef PERF_CNT_EN
    logic [CW-1:0]   nStall;
    logic [CW-1:0]   nFlush;
    logic [CW-1:0]   nInt;
`endif
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic idValid = 1'b0, idUse1 = 1'b0, idUse2 = 1'b0;
  logic exValid = 1'b0, exMemRead = 1'b0, brTaken = 1'b0, intReq = 1'b0;
  logic [AW-1:0] idRsrc1 = '0, idRsrc2 = '0, exRdst = '0;
  logic [NREG-1:0] stageEn, stageFlush;
  logic [1:0] pcSel;
  logic epcLoad, epcSrc, intAck;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stallCnt, flushCnt, intCnt;
`endif

  pipeline_ctrl #(.STAGES(STAGES), .EX_STAGE(EX), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(idValid), .id_rsrc1(idRsrc1), .id_rsrc2(idRsrc2),
    .id_use1(idUse1), .id_use2(idUse2),
    .ex_valid(exValid), .ex_mem_read(exMemRead), .ex_rdst(exRdst),
    .br_taken(brTaken), .int_req(intReq),
    .stage_en(stageEn), .stage_flush(stageFlush), .pc_sel(pcSel),
    .epc_load(epcLoad), .epc_src(epcSrc), .int_ack(intAck)
`ifdef PERF_CNT_EN
    , .stall_cnt(stallCnt), .flush_cnt(flushCnt), .int_cnt(intCnt)
`endif
  );

  always #5 clk = ~clk;

  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: an interrupt is "in flight" from its acceptance cycle;
  // its phase (cycles since acceptance) decides drain vs. vector behaviour.
  int  cyc = 0;
  int  tAcc = 0;
  bit  busy = 0;
  bit  armed = 1;
  int unsigned nStall = 0, nFlush = 0, nInt = 0;

  function automatic int unsigned satInc(int unsigned v);
    return (v < (2**CW - 1)) ? v + 1 : v;
  endfunction

  task automatic model(input stim_t s);
    obs_t e;
    int   ph;
    bit   lu, acc;
    e = '0;
    e.en = '1;
    acc = 0;
    if (!s.rstn) begin
      busy = 0; armed = 1; nStall = 0; nFlush = 0; nInt = 0;
      e.flush = '1;
      e.pc    = 2'b11;
    end else begin
`ifdef PERF_CNT_EN
      e.nStall = CW'(nStall); e.nFlush = CW'(nFlush); e.nInt = CW'(nInt);
`endif
      ph = cyc - tAcc;
      lu = s.idv && s.exv && s.exm && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (busy && ph <= DRAINC) begin
        for (int k = 0; k < EX; k++) e.flush[k] = 1'b1;
        e.pc = 2'b11;
        if (s.br) begin e.epcLoad = 1'b1; e.epcSrc = 1'b1; end
      end else if (busy) begin
        e.flush[0] = 1'b1;
        e.pc  = 2'b10;
        e.ack = 1'b1;
        busy  = 0;
        nInt  = satInc(nInt);
      end else if (s.br) begin
        for (int k = 0; k < EX; k++) e.flush[k] = 1'b1;
        e.pc   = 2'b01;
        nFlush = satInc(nFlush);
      end else if (lu) begin
        e.en[0]        = 1'b0;
        e.flush[EX-1]  = 1'b1;
        e.pc           = 2'b11;
        nStall         = satInc(nStall);
      end else if (s.ir && armed) begin
        for (int k = 0; k < EX; k++) e.flush[k] = 1'b1;
        e.pc      = 2'b11;
        e.epcLoad = 1'b1;
        acc  = 1;
        busy = 1;
        tAcc = cyc;
      end
      if (acc)        armed = 0;
      else if (!s.ir) armed = 1;
    end
    cyc++;
    expQ.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rstn; idValid = s.idv; idRsrc1 = s.rs1; idRsrc2 = s.rs2;
    idUse1 = s.u1; idUse2 = s.u2; exValid = s.exv; exMemRead = s.exm;
    exRdst = s.rd; brTaken = s.br; intReq = s.ir;
    model(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic stim_t loadHit(input logic use2);
    stim_t s;
    s = idle();
    s.idv = 1; s.exv = 1; s.exm = 1; s.rd = 3'd3; s.rs2 = 3'd3; s.u2 = use2; s.rs1 = 3'd5;
    return s;
  endfunction

  function automatic stim_t rnd(input logic irPrev);
    stim_t s;
    s.rstn = ($urandom_range(0, 149) != 0);
    s.idv = 1'($urandom); s.rs1 = AW'($urandom); s.rs2 = AW'($urandom);
    s.u1 = 1'($urandom); s.u2 = 1'($urandom);
    s.exv = 1'($urandom); s.exm = 1'($urandom); s.rd = AW'($urandom);
    s.br = ($urandom_range(0, 7) == 0);
    s.ir = ($urandom_range(0, 5) == 0) ? ~irPrev : irPrev;
    return s;
  endfunction

  always @(negedge clk) begin
    obs_t a, e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = '0;
      a.en = stageEn; a.flush = stageFlush; a.pc = pcSel;
      a.epcLoad = epcLoad; a.ack = intAck;
      a.epcSrc = e.epcLoad ? epcSrc : 1'b0;
`ifdef PERF_CNT_EN
      a.nStall = stallCnt; a.nFlush = flushCnt; a.nInt = intCnt;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got en=%b fl=%b pc=%b epc=%b/%b ack=%b exp en=%b fl=%b pc=%b epc=%b/%b ack=%b (full got=%h exp=%h)",
                 $time, a.en, a.flush, a.pc, a.epcLoad, a.epcSrc, a.ack,
                 e.en, e.flush, e.pc, e.epcLoad, e.epcSrc, e.ack, a, e);
      end
    end
  end

  initial begin
    stim_t s;
    logic  ir;
    // Reset with random inputs, then release.
    for (int i = 0; i < 3; i++) begin s = rnd(1'b0); s.rstn = 1'b0; apply(s); end
    apply(idle());
    apply(idle());
    // Load-use hit, then same without the second source being read.
    apply(loadHit(1'b1));
    apply(loadHit(1'b0));
    apply(idle());
    // Branch together with a load-use hit.
    s = loadHit(1'b1); s.br = 1'b1; apply(s);
    apply(idle());
    // Interrupt held high across entry, then dropped and re-raised.
    s = idle(); s.ir = 1'b1;
    for (int i = 0; i < 9; i++) apply(s);
    apply(idle());
    for (int i = 0; i < 6; i++) apply(s);
    for (int i = 0; i < 2; i++) apply(idle());
    // Branch resolving during drain (T+2).
    s = idle(); s.ir = 1'b1; apply(s);
    s.ir = 1'b0; apply(s);
    s.br = 1'b1; apply(s);
    s.br = 1'b0;
    for (int i = 0; i < 4; i++) apply(s);
    // Reset mid-drain, then a fresh request is accepted normally.
    s = idle(); s.ir = 1'b1; apply(s);
    s.ir = 1'b0; apply(s);
    s.rstn = 1'b0; apply(s);
    s.rstn = 1'b1;
    for (int i = 0; i < 5; i++) apply(s);
    s.ir = 1'b1; apply(s);
    s.ir = 1'b0;
    for (int i = 0; i < 6; i++) apply(s);
    // Randomised traffic.
    ir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s = rnd(ir);
      ir = s.ir;
      apply(s);
    end
    apply(idle());
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries exp 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline control unit for the core's in-order pipeline. It generates per-register enable and flush for every inter-stage pipeline register. It resolves load-use stalls and taken-branch flushes, and sequences interrupt entry through a drain state machine. It sits beside the datapath and drives the stage buffers' enable/rst inputs and the fetch PC-select.

## Interface
Parameters:
- STAGES, 5, pipeline depth; pipeline registers indexed 0..STAGES-2 (bit k sits between stage k and k+1)
- EX_STAGE, 2, index of execute stage (branch resolution, load in flight); 1 ≤ EX_STAGE ≤ STAGES-2
- REG_ADDR_W, 3, register-file address width
- CNT_W, 16, performance-counter width

Ports (clk and rst first):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rsrc1, id_rsrc2  in  REG_ADDR_W  decode source registers
- id_use1, id_use2  in  1  source actually read
- ex_valid  in  1  execute holds a valid instruction
- ex_mem_read  in  1  execute instruction is a load
- ex_rdst  in  REG_ADDR_W  execute destination
- br_taken  in  1  branch/call/jump taken, resolved in execute
- int_req  in  1  level interrupt request
- stage_en  out  STAGES-1  pipeline register load enable
- stage_flush  out  STAGES-1  pipeline register clear (bubble), priority over enable
- pc_sel  out  2  00 sequential, 01 branch target, 10 IVT, 11 hold
- epc_load  out  1  datapath captures EPC this cycle
- epc_src  out  1  0 = decode PC, 1 = branch target
- int_ack  out  1  one-cycle acknowledge
- stall_cnt, flush_cnt, int_cnt  out  CNT_W  (PERF_CNT_EN only)

## Operation
- State machine has three states: RUN, DRAIN, VECTOR. It also keeps a drain counter and an `armed` bit.
- **Defaults.** In RUN with no event: stage_en all 1, stage_flush all 0, pc_sel 00.
- **Load-use.** Condition: id_valid & ex_valid & ex_mem_read & ((id_use1 & id_rsrc1==ex_rdst) | (id_use2 & id_rsrc2==ex_rdst)).
  - stage_en[0]=0 (hold fetch/decode register).
  - stage_flush[EX_STAGE-1]=1 (bubble into execute).
  - pc_sel=11.
- **Branch taken.** stage_flush[EX_STAGE-1:0]=1 and pc_sel=01.
  - Branch beats load-use.
  - Branch beats interrupt acceptance.
- **Interrupt acceptance.** Occurs in RUN when int_req & armed & no branch & no load-use.
  - Same cycle: stage_flush[EX_STAGE-1:0]=1, pc_sel=11, epc_load=1, epc_src=0.
  - Next state DRAIN; counter loaded with STAGES-EX_STAGE-1; armed cleared.
- **DRAIN.**
  - stage_flush[EX_STAGE-1:0]=1, pc_sel=11.
  - Counter decrements each cycle; at 0 the next state is VECTOR.
  - br_taken here gives epc_load=1, epc_src=1. No redirect; pc_sel stays 11.
  - Load-use cannot occur here because decode is flushed; it is ignored.
- **VECTOR.** One cycle: pc_sel=10, int_ack=1, stage_flush[0]=1. Next state RUN.
- **Re-arming.** armed is set on any cycle with int_req=0. A request held high after int_ack is therefore not re-accepted.

## Timing
- Stall, flush and pc_sel are combinational from the current inputs and state (same-cycle effect). State, counter and armed are registered.
- Interrupt accepted at cycle T: DRAIN covers T+1..T+(STAGES-EX_STAGE), and VECTOR follows in the next cycle (T+4 for defaults). RUN resumes at T+5.
- Load-use stall lasts exactly 1 cycle, because the bubble clears ex_mem_read.
- **While rst=0:**
  - stage_flush all 1, stage_en all 1, pc_sel=11.
  - epc_load=0, int_ack=0.
  - State RUN, counter 0, armed=1, perf counters 0.
- **rst asserted mid-DRAIN:** the unit returns to RUN immediately and asynchronously; no int_ack is issued.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments per load-use stall cycle.
  - flush_cnt increments per branch flush.
  - int_cnt increments per int_ack.
  - All counters saturate at 2^CNT_W-1.
- PERF_CNT_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN/DRAIN/VECTOR);
  - pc_sel codes PC_SEQ/PC_BR/PC_IVT/PC_HOLD;
  - epc_src codes.
- One sub-module, pipeline_perf_cnt: a saturating CNT_W counter with increment input. It is instantiated three times under PERF_CNT_EN.

## Test plan
- **Reset.** rst=0 with random inputs → stage_flush=4'b1111, pc_sel=11, int_ack=0. Release rst → stage_en=4'b1111, stage_flush=0, pc_sel=00.
- **Load-use.** ex_mem_read=1, ex_rdst=3, id_rsrc2=3, id_use2=1 for one cycle → stage_en[0]=0, stage_flush[1]=1, pc_sel=11, stall_cnt=1. With id_use2=0 → no stall.
- **Branch vs. load-use.** br_taken together with a load-use hit → stage_flush=4'b0011, pc_sel=01, stall_cnt unchanged, flush_cnt=1.
- **Interrupt entry.** int_req=1 at cycle T with no hazard → epc_load=1, epc_src=0 at T; pc_sel=11 for T..T+3; pc_sel=10 and int_ack=1 at T+4; int_req held high → no second ack until it drops for ≥1 cycle.
- **Branch during DRAIN.** br_taken at T+2 → epc_load=1, epc_src=1, pc_sel stays 11, int_ack still at T+4.
- **Reset mid-DRAIN.** rst=0 at T+2 → int_ack never asserts; after release the next int_req is accepted normally.
